// File: rtl/wb_sram_slave.sv
// wb_sram_slave
//   Wishbone classic-cycle slave mapping one word-addressed asynchronous SRAM
//   window onto a 32-bit bus. Reads hold the SRAM enabled for READ_WAIT
//   cycles before sampling data. Writes use a setup cycle, then WRITE_WAIT
//   cycles of we_n low, then a hold cycle. Every accepted request ends in
//   exactly one ack (hit) or err (miss) pulse. All outputs are registered.
//
//   Valid/ready semantics: a request is wb_cyc_i & wb_stb_i seen in IDLE.
//   The master holds the request until it sees wb_ack_o or wb_err_o for one
//   cycle. Dropping wb_cyc_i mid-transfer aborts without a termination pulse.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   wb_cyc_i, wb_stb_i    bus cycle / strobe
//   wb_we_i               1 = write
//   wb_adr_i, wb_dat_i    byte address, write data
//   wb_sel_i              byte lanes
//   wb_dat_o              read data, held until the next completed read
//   wb_ack_o, wb_err_o    termination pulses
//   wb_rty_o              retry, always 0
//   sram_addr             SRAM word address
//   sram_data_o/_i/_oe    SRAM data out / in / output-drive enable
//   sram_ce_n, sram_oe_n, sram_we_n, sram_be_n   active-low SRAM controls
module wb_sram_slave #(
   parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
   parameter int          ADDR_WIDTH = 20,
   parameter int          READ_WAIT  = 2,
   parameter int          WRITE_WAIT = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wb_cyc_i,
   input  logic                  wb_stb_i,
   input  logic                  wb_we_i,
   input  logic [31:0]           wb_adr_i,
   input  logic [31:0]           wb_dat_i,
   input  logic [3:0]            wb_sel_i,
   output logic [31:0]           wb_dat_o,
   output logic                  wb_ack_o,
   output logic                  wb_err_o,
   output logic                  wb_rty_o,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [31:0]           sram_data_o,
   input  logic [31:0]           sram_data_i,
   output logic                  sram_data_oe,
   output logic                  sram_ce_n,
   output logic                  sram_oe_n,
   output logic                  sram_we_n,
   output logic [3:0]            sram_be_n
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD, S_WR_SETUP, S_WR_PULSE, S_DONE, S_ERR
   } state_e;

   localparam int WAIT_MAX = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
   localparam int CW       = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
   localparam logic [CW-1:0] RD_LOAD = CW'(READ_WAIT - 1);
   localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_WAIT - 1);

   state_e                  state_q, state_d;
   logic [CW-1:0]           wait_q, wait_d;
   logic [3:0]              sel_q, sel_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [31:0]             wdata_q, wdata_d;
   logic [31:0]             rdata_q, rdata_d;
   logic                    ack_q, ack_d;
   logic                    err_q, err_d;
   logic                    ce_n_q, ce_n_d;
   logic                    oe_n_q, oe_n_d;
   logic                    we_n_q, we_n_d;
   logic                    data_oe_q, data_oe_d;
   logic [3:0]              be_n_q, be_n_d;

   logic req, hit, wr_tail;
   logic unused_adr;

   assign req = wb_cyc_i & wb_stb_i;
   assign hit = (wb_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
   // Byte offset within the word is irrelevant to a word-wide SRAM.
   assign unused_adr = ^wb_adr_i[1:0];

   // State register and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         wait_q    <= '0;
         sel_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         ce_n_q    <= 1'b1;
         oe_n_q    <= 1'b1;
         we_n_q    <= 1'b1;
         data_oe_q <= 1'b0;
         be_n_q    <= 4'hF;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         sel_q     <= sel_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         ce_n_q    <= ce_n_d;
         oe_n_q    <= oe_n_d;
         we_n_q    <= we_n_d;
         data_oe_q <= data_oe_d;
         be_n_q    <= be_n_d;
      end
   end

   // Next-state logic. wait_q counts the remaining cycles of RD / WR_PULSE.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               if (!hit) begin
                  state_d = S_ERR;
               end else if (wb_we_i) begin
                  state_d = S_WR_SETUP;
               end else begin
                  state_d = S_RD;
                  wait_d  = RD_LOAD;
               end
            end
         end
         S_RD: begin
            if (!wb_cyc_i)            state_d = S_IDLE;
            else if (wait_q == '0)    state_d = S_DONE;
            else                      wait_d  = wait_q - 1'b1;
         end
         S_WR_SETUP: begin
            if (!wb_cyc_i) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_WR_PULSE;
               wait_d  = WR_LOAD;
            end
         end
         S_WR_PULSE: begin
            if (!wb_cyc_i)            state_d = S_IDLE;
            else if (wait_q == '0)    state_d = S_DONE;
            else                      wait_d  = wait_q - 1'b1;
         end
         default: state_d = S_IDLE;  // DONE, ERR
      endcase
   end

   // Output logic: outputs are registered, so they are decoded from the
   // state being entered (state_d) rather than the current one.
   always_comb begin
      // DONE entered from WR_PULSE is the write data-hold cycle.
      wr_tail = (state_d == S_DONE) && (state_q == S_WR_PULSE);

      sel_d   = sel_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      if ((state_q == S_IDLE) && req) begin
         sel_d   = wb_sel_i;
         addr_d  = wb_adr_i[ADDR_WIDTH+1:2];
         wdata_d = wb_dat_i;
      end
      if ((state_q == S_RD) && wb_cyc_i && (wait_q == '0)) begin
         rdata_d = sram_data_i;
      end

      ce_n_d    = 1'b1;
      oe_n_d    = 1'b1;
      we_n_d    = 1'b1;
      data_oe_d = 1'b0;
      be_n_d    = 4'hF;
      case (state_d)
         S_RD: begin
            ce_n_d = 1'b0;
            oe_n_d = 1'b0;
            be_n_d = 4'b0000;
         end
         S_WR_SETUP: begin
            ce_n_d    = 1'b0;
            data_oe_d = 1'b1;
            be_n_d    = ~sel_d;
         end
         S_WR_PULSE: begin
            ce_n_d    = 1'b0;
            data_oe_d = 1'b1;
            we_n_d    = 1'b0;
            be_n_d    = ~sel_d;
         end
         S_DONE: begin
            if (wr_tail) begin
               ce_n_d    = 1'b0;
               data_oe_d = 1'b1;
               be_n_d    = ~sel_d;
            end
         end
         default: ;
      endcase

      ack_d = (state_d == S_DONE);
      err_d = (state_d == S_ERR);
   end

   assign wb_dat_o     = rdata_q;
   assign wb_ack_o     = ack_q;
   assign wb_err_o     = err_q;
   assign wb_rty_o     = 1'b0;
   assign sram_addr    = addr_q;
   assign sram_data_o  = wdata_q;
   assign sram_data_oe = data_oe_q;
   assign sram_ce_n    = ce_n_q;
   assign sram_oe_n    = oe_n_q;
   assign sram_we_n    = we_n_q;
   assign sram_be_n    = be_n_q;

endmodule

// File: tb/tb_wb_sram_slave.sv
// tb_wb_sram_slave
//   Directed bench for wb_sram_slave with a behavioural async-SRAM model.
//   Requests push their expected termination {err, cycle, data} into exp_q;
//   a monitor pops and compares whenever ack or err is seen. SRAM control
//   timing is sampled per cycle by the driver and compared after each request.
module tb_wb_sram_slave;

   logic        clk, rst;
   logic        wb_cyc_i, wb_stb_i, wb_we_i;
   logic [31:0] wb_adr_i, wb_dat_i;
   logic [3:0]  wb_sel_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o, wb_err_o, wb_rty_o;
   logic [19:0] sram_addr;
   logic [31:0] sram_data_o, sram_data_i;
   logic        sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n;
   logic [3:0]  sram_be_n;

   wb_sram_slave dut (
      .clk(clk), .rst(rst),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
      .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
      .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
      .wb_rty_o(wb_rty_o), .sram_addr(sram_addr), .sram_data_o(sram_data_o),
      .sram_data_i(sram_data_i), .sram_data_oe(sram_data_oe),
      .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
      .sram_be_n(sram_be_n)
   );

   // ---------------- clock / reset ----------------
   int cycle_cnt = 0;
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   // ---------------- SRAM model ----------------
   logic [31:0] mem [0:255];
   logic        preload;
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
         mem[8'h10] <= 32'hDEADBEEF;
         mem[8'h11] <= 32'h11223344;
         mem[8'h20] <= 32'hCAFEF00D;
      end else if (!sram_ce_n && !sram_we_n) begin
         for (int b = 0; b < 4; b++)
            if (!sram_be_n[b]) mem[sram_addr[7:0]][8*b +: 8] <= sram_data_o[8*b +: 8];
      end
   end
   assign sram_data_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 32'h0;

   // ---------------- scoreboard ----------------
   int chk_cnt  = 0;
   int pass_cnt = 0;
   logic [48:0] exp_q[$];   // {err, cycle[15:0], data[31:0]}

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cycle_cnt);
   endtask

   always @(negedge clk) begin
      logic [48:0] item;
      if (!rst && (wb_ack_o || wb_err_o)) begin
         check("ack_err_excl", 32'(wb_ack_o & wb_err_o), 32'h0);
         if (exp_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL unexpected_resp: got ack=%0d err=%0d at cycle %0d expected none",
                     wb_ack_o, wb_err_o, cycle_cnt);
         end else begin
            item = exp_q.pop_front();
            check("resp_kind", 32'(wb_err_o), 32'(item[48]));
            check("resp_cycle", 32'(cycle_cnt[15:0]), 32'(item[47:32]));
            if (!item[48]) check("resp_data", wb_dat_o, item[31:0]);
         end
      end
   end

   // ---------------- driver ----------------
   logic        s_ce_n[0:15], s_oe_n[0:15], s_we_n[0:15], s_doe[0:15];
   logic [3:0]  s_be_n[0:15];
   logic [19:0] s_addr[0:15];
   logic [31:0] s_dato[0:15];

   task automatic bus_idle();
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
   endtask

   // Issue one request, sample the SRAM pins for 15 cycles (index = cycle
   // number relative to the request), drop cyc/stb on termination or at
   // abort_at (0 = never).
   task automatic run_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int abort_at, input logic exp_resp,
                          input logic exp_err, input int exp_off, input logic [31:0] exp_dat);
      logic got_resp = 1'b0;
      @(negedge clk);
      if (exp_resp) exp_q.push_back({exp_err, 16'(cycle_cnt + exp_off), exp_dat});
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
      wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
      for (int k = 1; k < 16; k++) begin
         @(negedge clk);
         s_ce_n[k] = sram_ce_n; s_oe_n[k] = sram_oe_n; s_we_n[k] = sram_we_n;
         s_doe[k]  = sram_data_oe; s_be_n[k] = sram_be_n;
         s_addr[k] = sram_addr; s_dato[k] = sram_data_o;
         if (wb_ack_o || wb_err_o) begin
            got_resp = 1'b1;
            bus_idle();
         end
         if (k == abort_at) bus_idle();
      end
      check(exp_resp ? "resp_seen" : "no_resp", 32'(got_resp), 32'(exp_resp));
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int n_ack;
      rst = 1'b1; preload = 1'b1;
      bus_idle(); wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
      repeat (3) @(negedge clk);
      preload = 1'b0;
      rst = 1'b0;

      // Reset state
      check("rst_dat_o", wb_dat_o, 32'h0);
      check("rst_ack", 32'(wb_ack_o), 32'h0);
      check("rst_err", 32'(wb_err_o), 32'h0);
      check("rst_rty", 32'(wb_rty_o), 32'h0);
      check("rst_addr", 32'(sram_addr), 32'h0);
      check("rst_data_o", sram_data_o, 32'h0);
      check("rst_ctrl", 32'({sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n}), 32'h7F);

      // Read word 0x10: enabled cycles 1-2, ack in cycle 3
      run_req(1'b0, 32'h8000_0040, 32'h0, 4'hF, 0, 1'b1, 1'b0, 3, 32'hDEADBEEF);
      check("rd_addr", 32'(s_addr[1]), 32'h10);
      check("rd_c1", 32'({s_ce_n[1], s_oe_n[1], s_doe[1], s_be_n[1]}), 32'h00);
      check("rd_c2", 32'({s_ce_n[2], s_oe_n[2], s_we_n[2]}), 32'h1);
      check("rd_c3", 32'({s_ce_n[3], s_oe_n[3]}), 32'h3);

      // Byte write to word 0x11 lane 1: setup 1, we_n low 2-3, ack 4
      run_req(1'b1, 32'h8000_0044, 32'h0000AB00, 4'b0010, 0, 1'b1, 1'b0, 4, 32'hDEADBEEF);
      check("wr_setup", 32'({s_ce_n[1], s_we_n[1], s_doe[1], s_be_n[1]}), 32'h3D);
      check("wr_data", s_dato[1], 32'h0000AB00);
      check("wr_pulse", 32'({s_we_n[1], s_we_n[2], s_we_n[3], s_we_n[4]}), 32'h9);
      check("wr_hold", 32'({s_ce_n[4], s_doe[4], s_be_n[4]}), 32'h1D);
      check("wr_release", 32'({s_ce_n[5], s_doe[5], s_be_n[5]}), 32'h2F);
      run_req(1'b0, 32'h8000_0044, 32'h0, 4'hF, 0, 1'b1, 1'b0, 3, 32'h1122AB44);

      // sel = 0 write runs the full sequence but leaves the word unchanged
      run_req(1'b1, 32'h8000_0045, 32'hFFFFFFFF, 4'b0000, 0, 1'b1, 1'b0, 4, 32'h1122AB44);
      check("wr_sel0", 32'({s_ce_n[2], s_we_n[2], s_be_n[2]}), 32'h0F);
      run_req(1'b0, 32'h8000_0044, 32'h0, 4'hF, 0, 1'b1, 1'b0, 3, 32'h1122AB44);

      // Miss: err in cycle 1, SRAM never enabled
      run_req(1'b0, 32'h1000_0000, 32'h0, 4'hF, 0, 1'b1, 1'b1, 1, 32'h0);
      for (int k = 1; k <= 5; k++) check("miss_ce_n", 32'(s_ce_n[k]), 32'h1);

      // Abort in cycle 1 of a read: idle in cycle 2, wb_dat_o unchanged
      run_req(1'b0, 32'h8000_0040, 32'h0, 4'hF, 1, 1'b0, 1'b0, 0, 32'h0);
      check("abort_c2", 32'({s_ce_n[2], s_oe_n[2]}), 32'h3);
      check("abort_dat", wb_dat_o, 32'h1122AB44);

      // Back-to-back reads with stb held: acks in cycles 3 and 7
      @(negedge clk);
      exp_q.push_back({1'b0, 16'(cycle_cnt + 3), 32'hDEADBEEF});
      exp_q.push_back({1'b0, 16'(cycle_cnt + 7), 32'hCAFEF00D});
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
      wb_adr_i = 32'h8000_0040; wb_sel_i = 4'hF;
      n_ack = 0;
      for (int k = 1; k < 14; k++) begin
         @(negedge clk);
         if (wb_ack_o) begin
            n_ack++;
            if (n_ack == 1) wb_adr_i = 32'h8000_0080;
            else bus_idle();
         end
      end
      bus_idle();
      check("b2b_acks", 32'(n_ack), 32'd2);

      // Reset in cycle 2 of a write: controls release immediately, no ack
      @(negedge clk);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
      wb_adr_i = 32'h8000_0048; wb_dat_i = 32'h12345678; wb_sel_i = 4'hF;
      @(negedge clk);
      @(negedge clk);
      check("rstw_pulse_active", 32'(sram_we_n), 32'h0);
      #2 rst = 1'b1;
      #1;
      check("rstw_ctrl", 32'({sram_we_n, sram_ce_n, sram_data_oe, sram_be_n}), 32'h6F);
      check("rstw_ack", 32'(wb_ack_o), 32'h0);
      check("rstw_dat_o", wb_dat_o, 32'h0);
      bus_idle();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("rstw_no_write", mem[8'h12], 32'h0);
      run_req(1'b0, 32'h8000_0044, 32'h0, 4'hF, 0, 1'b1, 1'b0, 3, 32'h1122AB44);

      repeat (4) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'h0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
